// File: rtl/vc_test_rand_delay_source.sv
// vc_test_rand_delay_source: replays table m[] on val/rdy with LFSR-drawn idle gaps; VC_TEST_SRC_STALL_COUNT_EN adds num_stalls
module vc_test_rand_delay_source #(
  parameter int          p_msg_nbits = 1,
  parameter int          p_num_msgs  = 1024,
  parameter logic [15:0] p_seed      = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            max_delay,
  input  logic [31:0]            num_msgs,
  output logic                   val,
  input  logic                   rdy,
  output logic [p_msg_nbits-1:0] msg,
  output logic                   done
`ifdef VC_TEST_SRC_STALL_COUNT_EN
  ,
  output logic [31:0]            num_stalls
`endif
);
  localparam int AW = p_num_msgs > 1 ? $clog2(p_num_msgs) : 1;
  typedef enum logic [1:0] {S_WAIT, S_SEND, S_DONE} state_t;
  state_t state, state_next;
  logic [31:0] idx, cnt, d;
  logic [15:0] lfsr;
  logic fire;
  logic [p_msg_nbits-1:0] m [0:p_num_msgs-1];
  assign fire = state == S_SEND && rdy;
  // all-ones max_delay would wrap max_delay+1 to zero, and lfsr is already below 2^32
  assign d = max_delay == 32'd0          ? 32'd0 :
             max_delay == 32'hFFFF_FFFF  ? {16'b0, lfsr} :
             {16'b0, lfsr} % (max_delay + 32'd1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      idx   <= '0;
      cnt   <= '0;
      lfsr  <= p_seed;
    end else begin
      state <= state_next;
      if (state == S_WAIT && cnt != 32'd0) cnt <= cnt - 32'd1;
      if (fire) begin
        idx  <= idx + 32'd1;
        cnt  <= d;
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
    end
  end
  always_comb begin
    state_next = state;
    if (state == S_WAIT && cnt == 32'd0)
      state_next = idx < num_msgs ? S_SEND : S_DONE;
    else if (fire)
      state_next = idx + 32'd1 == num_msgs ? S_DONE : d == 32'd0 ? S_SEND : S_WAIT;
  end
  always_comb begin
    val  = !reset && state == S_SEND;
    done = !reset && state == S_DONE;
    msg  = m[idx[AW-1:0]];
  end
`ifdef VC_TEST_SRC_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) num_stalls <= '0;
    else if (val && !rdy && num_stalls != 32'hFFFF_FFFF) num_stalls <= num_stalls + 32'd1;
  end
`endif
endmodule

// File: tb/tb_vc_test_rand_delay_source.sv
// tb_vc_test_rand_delay_source: scoreboard bench; expected (msg, idle gap) per handshake queued by stimulus
module tb_vc_test_rand_delay_source;
  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] max_delay = 0;
  logic [31:0] num_msgs = 4;
  logic        val;
  logic        rdy = 1;
  logic [7:0]  msg;
  logic        done;
`ifdef VC_TEST_SRC_STALL_COUNT_EN
  logic [31:0] num_stalls;
`endif
  vc_test_rand_delay_source #(.p_msg_nbits(8), .p_num_msgs(32), .p_seed(16'hACE1)) dut (
    .clk(clk), .reset(reset), .max_delay(max_delay), .num_msgs(num_msgs),
    .val(val), .rdy(rdy), .msg(msg), .done(done)
`ifdef VC_TEST_SRC_STALL_COUNT_EN
    , .num_stalls(num_stalls)
`endif
  );
  always #5 clk = ~clk;
  typedef struct { logic [7:0] msg; int gap; } item_t;
  item_t sb[$];
  logic [7:0] m_tab [0:31];
  int pass_cnt = 0, total = 0, low = 0, hs = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  // gap = val-low cycles before each handshake; first message sees one idle cycle after reset
  task automatic push_run(input int n, input int maxd);
    logic [15:0] l;
    int g, dd;
    l = 16'hACE1;
    g = 1;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{m_tab[i], g});
      dd = maxd == 0 ? 0 : int'(l) % (maxd + 1);
      g = dd == 0 ? 0 : dd + 1;
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endtask
  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask
  task automatic wait_empty(input string n, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (sb.size() != 0) chk({n, "_timeout"}, 32'(sb.size()), 0);
    else begin
      chk({n, "_done_pre"}, 32'(done), 0);
      @(negedge clk);
      chk({n, "_done"}, 32'(done), 1);
      chk({n, "_val_after"}, 32'(val), 0);
    end
  endtask
  always @(negedge clk) begin
    item_t it;
    if (reset) begin
      low = 0;
      hs = 0;
      chk("val_in_reset", 32'(val), 0);
      chk("done_in_reset", 32'(done), 0);
    end else if (val && rdy) begin
      if (sb.size() == 0) chk("unexpected_msg", 32'(msg), 32'hFFFF_FFFF);
      else begin
        it = sb.pop_front();
        chk("msg", 32'(msg), 32'(it.msg));
        chk("gap", 32'(low), 32'(it.gap));
      end
      low = 0;
      hs++;
    end else if (!val) low++;
  end
  initial begin
    int k;
    for (int i = 0; i < 32; i++) begin
      m_tab[i] = 8'(8'h11 * (i + 1));
      dut.m[i] = m_tab[i];
    end
    // back-to-back: 11,22,33,44 with no gaps after the first
    max_delay = 0; num_msgs = 4; rdy = 1;
    sb.push_back('{8'h11, 1}); sb.push_back('{8'h22, 0});
    sb.push_back('{8'h33, 0}); sb.push_back('{8'h44, 0});
    do_reset();
    wait_empty("b2b", 50);
    // three-cycle stall on m[1]
    sb.push_back('{8'h11, 1}); sb.push_back('{8'h22, 0});
    sb.push_back('{8'h33, 0}); sb.push_back('{8'h44, 0});
    do_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdy = 0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_val", 32'(val), 1);
      chk("stall_msg", 32'(msg), 32'h22);
      @(posedge clk); #1;
    end
    rdy = 1;
    wait_empty("stall", 50);
`ifdef VC_TEST_SRC_STALL_COUNT_EN
    chk("num_stalls", num_stalls, 3);
`endif
    // random gaps, max_delay=7, 16 messages
    max_delay = 7; num_msgs = 16;
    push_run(16, 7);
    do_reset();
    wait_empty("rand", 400);
    // empty table run
    num_msgs = 0;
    do_reset();
    @(negedge clk);
    chk("zero_done_c1", 32'(done), 0);
    chk("zero_val_c1", 32'(val), 0);
    @(negedge clk);
    chk("zero_done_c2", 32'(done), 1);
    repeat (4) begin
      @(negedge clk);
      chk("zero_val", 32'(val), 0);
    end
    // reset one cycle after the 2nd handshake, then full replay
    num_msgs = 16;
    push_run(16, 7);
    do_reset();
    k = 0;
    while (hs < 2 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    chk("mid_hs_reached", 32'(hs >= 2), 1);
    @(posedge clk); #1;
    reset = 1;
    sb.delete();
    push_run(16, 7);
    do_reset();
    wait_empty("replay", 400);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
